dmem_lsu: RTL and testbench
===========================

Name: dmem_lsu

Overview:
Parametrised load/store unit between the RV32I core and data memory. It replaces the core's fixed single-cycle, always-ready data-memory connection with the following:
- a valid/ready request handshake;
- byte-lane strobe generation and load alignment/extension;
- misalignment detection;
- a variable-latency memory port with a bus-timeout watchdog.

The core stalls on `core_stall` while an access is in flight.

Parameters:
- XLEN, 32, data width in bits; legal values are 32 or 64. Doubleword and word-unsigned modes are legal only when XLEN=64.
- ADDR_W, 32, byte-address width.
- TIMEOUT_CYC, 255, cycles allowed in WAIT before a bus error is raised; the counter width is clog2(TIMEOUT_CYC+1).
- STRB_W, XLEN/8, number of byte strobes; derived, not overridable.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- req_valid  in  1  core requests a data-memory access
- req_we  in  1  1 = store, 0 = load
- req_mode  in  3  RISC-V funct3: 000 B, 001 H, 010 W, 011 D, 100 BU, 101 HU, 110 WU
- req_addr  in  ADDR_W  byte address (the ALU result)
- req_wdata  in  XLEN  store data (rs2), LSB-justified
- req_ready  out  1  LSU accepts a request this cycle
- core_stall  out  1  core must hold its PC and register writes
- rsp_valid  out  1  one-cycle pulse when the load data or store completion is final
- rsp_rdata  out  XLEN  aligned, extended load data
- rsp_err  out  2  00 ok, 01 misaligned, 10 bus timeout, 11 illegal mode; valid with rsp_valid
- mem_req  out  1  memory request
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  address aligned to XLEN/8 bytes (low bits zero)
- mem_wstrb  out  STRB_W  byte enables
- mem_wdata  out  XLEN  store data shifted into the correct lanes
- mem_gnt  in  1  memory accepts the request
- mem_rvalid  in  1  memory response (read data, or write acknowledge)
- mem_rdata  in  XLEN  read word

Behaviour:
- Reset (reset=0, asynchronous):
  - state = IDLE;
  - all registered outputs are 0;
  - req_ready = 1 once reset is released; core_stall = 0.
- States:
  - IDLE → ERR on an accepted request that fails the checks (checks below).
  - IDLE → REQ on an accepted legal request; addr, mode, we, shifted wdata and wstrb are latched.
  - REQ → WAIT when mem_gnt=1. mem_req is held with stable outputs until granted.
  - WAIT → RESP when mem_rvalid=1.
  - WAIT → ERR when the timeout counter reaches TIMEOUT_CYC.
  - RESP → IDLE after 1 cycle.
  - ERR → IDLE after 1 cycle.
- Request acceptance: a request is accepted when req_valid && req_ready.
- Request checks, applied at acceptance:
  - Illegal mode: mode 111; or modes 011 and 110 when XLEN=32.
  - Misaligned: H/HU with addr[0] != 0; W/WU with addr[1:0] != 0; D with addr[2:0] != 0.
  - Priority: illegal mode over misaligned.
  - A request that fails either check issues no memory access.
- req_ready = 1 only in IDLE.
- core_stall = req_valid && !(state == RESP || state == ERR). The core therefore advances exactly in the rsp_valid cycle.
- Minimum latency: acceptance at cycle 0 with mem_gnt=1 in REQ and mem_rvalid on the first WAIT cycle gives rsp_valid at cycle 3.
- Memory port: the timeout counter clears on entering WAIT. mem_gnt and mem_rvalid asserted in the same cycle while in REQ: the grant is taken, and rvalid is ignored until WAIT.
- Store lanes:
  - offset = addr mod STRB_W.
  - wstrb = (1 << size) − 1, shifted left by offset, where size is 1/2/4/8 bytes.
  - wdata = req_wdata << (8·offset).
- Load data:
  - The word is shifted right by 8·offset, then truncated to size.
  - B, H and W are sign-extended to XLEN.
  - BU, HU and WU are zero-extended.
  - D is passed through.
  - For stores and errors, rsp_rdata = 0.
- rsp_rdata holds its value until the next rsp_valid.
- Reset mid-transaction: return to IDLE immediately. A late mem_rvalid arriving in IDLE is ignored.

Decomposition:
- Package `lsu_pkg` contains:
  - funct3 mode constants;
  - state encoding (IDLE, REQ, WAIT, RESP, ERR);
  - rsp_err codes.
- Sub-module `lsu_align` is purely combinational. It produces strobe and shift for stores, and extract/extend for loads, parametrised by XLEN. It is instantiated once for the store path and once for the load path.

Test Plan:
- LW, XLEN=32: addr 0x104, mem_rdata 0xDEADBEEF, gnt=1, rvalid after 1 cycle → rsp_valid at cycle 3, rsp_rdata 0xDEADBEEF, err 00, core_stall=1 for cycles 0–2.
- LB/LBU: addr 0x103, mem_rdata 0x80FF_0000 → LB returns 0xFFFFFF80, LBU returns 0x00000080; mem_addr 0x100.
- SH: addr 0x22, wdata 0x0000ABCD → mem_wstrb 1100, mem_wdata 0xABCD0000, mem_addr 0x20, mem_we=1.
- Misaligned LW at 0x101, then illegal mode 111 → no mem_req; rsp_err 01 then 11, each one cycle after acceptance.
- mem_rvalid never asserted with TIMEOUT_CYC=8 → rsp_err 10 exactly 8 cycles after entering WAIT; FSM returns to IDLE; req_ready=1.
- XLEN=64: LD at 0x08 and LWU at 0x0C with mem_rdata 0xFFFFFFFF_12345678 → LD returns the full word; LWU returns 0x00000000_FFFFFFFF. Reset asserted while in WAIT → outputs clear asynchronously.

Source files
------------

// File: rtl/dmem_lsu_pkg.sv
// Shared definitions for the data-memory load/store unit: funct3 access
// modes, FSM state encoding, response error codes and request-check helpers.
package lsu_pkg;

    // RISC-V funct3 load/store width encodings
    localparam logic [2:0] MODE_B  = 3'b000;
    localparam logic [2:0] MODE_H  = 3'b001;
    localparam logic [2:0] MODE_W  = 3'b010;
    localparam logic [2:0] MODE_D  = 3'b011;
    localparam logic [2:0] MODE_BU = 3'b100;
    localparam logic [2:0] MODE_HU = 3'b101;
    localparam logic [2:0] MODE_WU = 3'b110;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_WAIT = 3'd2,
        ST_RESP = 3'd3,
        ST_ERR  = 3'd4
    } lsu_state_t;

    typedef enum logic [1:0] {
        ERR_OK       = 2'b00,
        ERR_MISALIGN = 2'b01,
        ERR_TIMEOUT  = 2'b10,
        ERR_ILLEGAL  = 2'b11
    } lsu_err_t;

    // Mode 111 never exists; D and WU only exist on a 64-bit datapath.
    function automatic logic mode_illegal(input logic [2:0] mode, input logic is_xlen64);
        return (mode == 3'b111) || (!is_xlen64 && (mode == MODE_D || mode == MODE_WU));
    endfunction

    // Natural alignment check; byte accesses are always aligned.
    function automatic logic addr_misaligned(input logic [2:0] mode, input logic [2:0] addr_lo);
        logic mis;
        case (mode)
            MODE_H, MODE_HU: mis = addr_lo[0];
            MODE_W, MODE_WU: mis = |addr_lo[1:0];
            MODE_D:          mis = |addr_lo;
            default:         mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/dmem_lsu_align.sv
// Combinational lane logic. The store path shifts data and strobes into the
// addressed byte lanes; the load path shifts the read word down, truncates it
// to the access size and sign- or zero-extends it.
module lsu_align
    import lsu_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter bit LOAD_PATH = 1'b0
) (
    input  logic [2:0]                 i_mode,
    input  logic [$clog2(XLEN/8)-1:0]  i_offset,
    input  logic [XLEN-1:0]            i_data,
    output logic [XLEN/8-1:0]          o_strb,
    output logic [XLEN-1:0]            o_data
);

    localparam int STRB_W = XLEN / 8;
    localparam int OFF_W  = $clog2(STRB_W);

    logic [7:0]         w_size_strb;
    logic [OFF_W+2:0]   w_bit_off;
    logic [XLEN-1:0]    w_store;
    logic [XLEN-1:0]    w_shift_dn;
    logic [XLEN-1:0]    w_load;

    assign w_bit_off  = {i_offset, 3'b000};
    assign w_store    = i_data << w_bit_off;
    assign w_shift_dn = i_data >> w_bit_off;
    assign o_strb     = w_size_strb[STRB_W-1:0] << i_offset;
    assign o_data     = LOAD_PATH ? w_load : w_store;

    // Unshifted byte-enable pattern for the access size
    always_comb begin
        // NOTE: every always_comb output gets a value on every path (default arm
        // here, default assignment below) so no latch is inferred.
        case (i_mode)
            MODE_B, MODE_BU: w_size_strb = 8'h01;
            MODE_H, MODE_HU: w_size_strb = 8'h03;
            MODE_W, MODE_WU: w_size_strb = 8'h0F;
            default:         w_size_strb = 8'hFF;
        endcase
    end

    // Truncate the shifted read word to the access size and extend it
    always_comb begin
        w_load = '0;
        case (i_mode)
            MODE_B:  w_load = XLEN'($signed(w_shift_dn[7:0]));
            MODE_H:  w_load = XLEN'($signed(w_shift_dn[15:0]));
            MODE_W:  w_load = XLEN'($signed(w_shift_dn[31:0]));
            MODE_D:  w_load = w_shift_dn;
            MODE_BU: w_load = XLEN'(w_shift_dn[7:0]);
            MODE_HU: w_load = XLEN'(w_shift_dn[15:0]);
            MODE_WU: w_load = XLEN'(w_shift_dn[31:0]);
            default: w_load = '0;
        endcase
    end

endmodule

// File: rtl/dmem_lsu.sv
// Load/store unit between the core and a variable-latency data memory:
// valid/ready request handshake, legality and alignment checks, byte-lane
// strobes, load extraction and a bus-timeout watchdog while waiting.
module dmem_lsu
    import lsu_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int ADDR_W      = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_valid,
    input  logic                 req_we,
    input  logic [2:0]           req_mode,
    input  logic [ADDR_W-1:0]    req_addr,
    input  logic [XLEN-1:0]      req_wdata,
    output logic                 req_ready,
    output logic                 core_stall,
    output logic                 rsp_valid,
    output logic [XLEN-1:0]      rsp_rdata,
    output logic [1:0]           rsp_err,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [ADDR_W-1:0]    mem_addr,
    output logic [XLEN/8-1:0]    mem_wstrb,
    output logic [XLEN-1:0]      mem_wdata,
    input  logic                 mem_gnt,
    input  logic                 mem_rvalid,
    input  logic [XLEN-1:0]      mem_rdata
);

    localparam int STRB_W = XLEN / 8;
    localparam int OFF_W  = $clog2(STRB_W);
    localparam int CNT_W  = $clog2(TIMEOUT_CYC + 1);

    lsu_state_t          r_state;
    logic [2:0]          r_mode;
    logic [OFF_W-1:0]    r_offset;
    logic                r_we;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_mem_req;
    logic                r_mem_we;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [STRB_W-1:0]   r_mem_wstrb;
    logic [XLEN-1:0]     r_mem_wdata;
    logic                r_rsp_valid;
    logic [XLEN-1:0]     r_rsp_rdata;
    logic [1:0]          r_rsp_err;

    logic [OFF_W-1:0]    w_offset;
    logic                w_illegal;
    logic                w_misalign;
    logic [STRB_W-1:0]   w_st_strb;
    logic [XLEN-1:0]     w_st_data;
    logic [XLEN-1:0]     w_ld_data;
    logic [STRB_W-1:0]   w_ld_strb_unused;  // read data is extracted by shift, lanes not needed
    logic [CNT_W-1:0]    w_cnt_next;

    assign w_offset   = req_addr[OFF_W-1:0];
    assign w_illegal  = mode_illegal(req_mode, XLEN == 64);
    assign w_misalign = addr_misaligned(req_mode, req_addr[2:0]);
    assign w_cnt_next = r_cnt + 1'b1;

    // Store lanes are computed from the live request and latched on acceptance
    lsu_align #(.XLEN(XLEN), .LOAD_PATH(1'b0)) u_store_align (
        .i_mode   (req_mode),
        .i_offset (w_offset),
        .i_data   (req_wdata),
        .o_strb   (w_st_strb),
        .o_data   (w_st_data)
    );

    // Load extraction uses the mode and offset latched at acceptance
    lsu_align #(.XLEN(XLEN), .LOAD_PATH(1'b1)) u_load_align (
        .i_mode   (r_mode),
        .i_offset (r_offset),
        .i_data   (mem_rdata),
        .o_strb   (w_ld_strb_unused),
        .o_data   (w_ld_data)
    );

    assign req_ready  = (r_state == ST_IDLE);
    assign core_stall = req_valid && !(r_state == ST_RESP || r_state == ST_ERR);
    assign rsp_valid  = r_rsp_valid;
    assign rsp_rdata  = r_rsp_rdata;
    assign rsp_err    = r_rsp_err;
    assign mem_req    = r_mem_req;
    assign mem_we     = r_mem_we;
    assign mem_addr   = r_mem_addr;
    assign mem_wstrb  = r_mem_wstrb;
    assign mem_wdata  = r_mem_wdata;

    // Transaction FSM with registered memory-port and response outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_mode      <= '0;
            r_offset    <= '0;
            r_we        <= 1'b0;
            r_cnt       <= '0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wstrb <= '0;
            r_mem_wdata <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            r_rsp_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        if (w_illegal || w_misalign) begin
                            r_state     <= ST_ERR;
                            r_rsp_valid <= 1'b1;
                            r_rsp_rdata <= '0;
                            r_rsp_err   <= w_illegal ? ERR_ILLEGAL : ERR_MISALIGN;
                        end else begin
                            r_state     <= ST_REQ;
                            r_mode      <= req_mode;
                            r_offset    <= w_offset;
                            r_we        <= req_we;
                            r_mem_req   <= 1'b1;
                            r_mem_we    <= req_we;
                            r_mem_addr  <= {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                            r_mem_wstrb <= w_st_strb;
                            r_mem_wdata <= w_st_data;
                        end
                    end
                end
                ST_REQ: begin
                    // a same-cycle mem_rvalid is deliberately not looked at here
                    if (mem_gnt) begin
                        r_state   <= ST_WAIT;
                        r_mem_req <= 1'b0;
                        r_mem_we  <= 1'b0;
                        r_cnt     <= '0;
                    end
                end
                ST_WAIT: begin
                    if (mem_rvalid) begin
                        r_state     <= ST_RESP;
                        r_rsp_valid <= 1'b1;
                        r_rsp_rdata <= r_we ? '0 : w_ld_data;
                        r_rsp_err   <= ERR_OK;
                    end else if (w_cnt_next == CNT_W'(TIMEOUT_CYC)) begin
                        r_state     <= ST_ERR;
                        r_rsp_valid <= 1'b1;
                        r_rsp_rdata <= '0;
                        r_rsp_err   <= ERR_TIMEOUT;
                    end else begin
                        r_cnt <= w_cnt_next;
                    end
                end
                ST_RESP: r_state <= ST_IDLE;
                ST_ERR:  r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_lsu.sv
// Self-checking bench: one 32-bit and one 64-bit LSU (both with an 8-cycle
// timeout) share the stimulus; sel64 routes requests and selects outputs.
module tb_dmem_lsu;

    logic        clk = 1'b0;
    logic        reset;
    logic        sel64;
    logic        req_valid, req_we;
    logic [2:0]  req_mode;
    logic [31:0] req_addr;
    logic [63:0] req_wdata;
    logic        mem_gnt, mem_rvalid;
    logic [63:0] mem_rdata;

    always #5 clk = ~clk;

    logic        v32, v64;
    logic        ready32, stall32, rv32, mreq32, mwe32;
    logic [31:0] rdata32, maddr32, mwdata32;
    logic [1:0]  err32;
    logic [3:0]  strb32;
    logic        ready64, stall64, rv64, mreq64, mwe64;
    logic [63:0] rdata64, mwdata64;
    logic [31:0] maddr64;
    logic [1:0]  err64;
    logic [7:0]  strb64;

    assign v32 = req_valid & ~sel64;
    assign v64 = req_valid & sel64;

    dmem_lsu #(.XLEN(32), .ADDR_W(32), .TIMEOUT_CYC(8)) u_dut32 (
        .clk(clk), .reset(reset), .req_valid(v32), .req_we(req_we), .req_mode(req_mode),
        .req_addr(req_addr), .req_wdata(req_wdata[31:0]), .req_ready(ready32),
        .core_stall(stall32), .rsp_valid(rv32), .rsp_rdata(rdata32), .rsp_err(err32),
        .mem_req(mreq32), .mem_we(mwe32), .mem_addr(maddr32), .mem_wstrb(strb32),
        .mem_wdata(mwdata32), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata[31:0])
    );

    dmem_lsu #(.XLEN(64), .ADDR_W(32), .TIMEOUT_CYC(8)) u_dut64 (
        .clk(clk), .reset(reset), .req_valid(v64), .req_we(req_we), .req_mode(req_mode),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(ready64),
        .core_stall(stall64), .rsp_valid(rv64), .rsp_rdata(rdata64), .rsp_err(err64),
        .mem_req(mreq64), .mem_we(mwe64), .mem_addr(maddr64), .mem_wstrb(strb64),
        .mem_wdata(mwdata64), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata)
    );

    logic        o_ready, o_stall, o_rv, o_mreq, o_mwe;
    logic [63:0] o_rdata, o_mwdata;
    logic [31:0] o_maddr;
    logic [1:0]  o_err;
    logic [7:0]  o_strb;

    assign o_ready  = sel64 ? ready64  : ready32;
    assign o_stall  = sel64 ? stall64  : stall32;
    assign o_rv     = sel64 ? rv64     : rv32;
    assign o_mreq   = sel64 ? mreq64   : mreq32;
    assign o_mwe    = sel64 ? mwe64    : mwe32;
    assign o_rdata  = sel64 ? rdata64  : {32'h0, rdata32};
    assign o_mwdata = sel64 ? mwdata64 : {32'h0, mwdata32};
    assign o_maddr  = sel64 ? maddr64  : maddr32;
    assign o_err    = sel64 ? err64    : err32;
    assign o_strb   = sel64 ? strb64   : {4'h0, strb32};

    typedef struct {
        bit          is64;
        bit          we;
        logic [2:0]  mode;
        logic [31:0] addr;
        logic [63:0] wdata;
        logic [63:0] rdata;
        int          gnt_dly;
        int          rv_dly;     // -1: memory never responds
        bit          early_rv;   // rvalid driven together with the grant
        bit          exp_mem;
        logic [31:0] exp_maddr;
        logic [7:0]  exp_strb;
        logic [63:0] exp_wdata;
        logic [63:0] exp_rdata;
        logic [1:0]  exp_err;
    } vec_t;

    typedef struct {
        logic [63:0] rdata;
        logic [1:0]  err;
        int          lat;
    } exp_t;

    vec_t vecs[$];
    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input bit is64, input bit we, input logic [2:0] mode,
                                input logic [31:0] addr, input logic [63:0] wdata,
                                input logic [63:0] rdata, input int gd, input int rd,
                                input bit early, input bit em, input logic [31:0] ma,
                                input logic [7:0] es, input logic [63:0] ew,
                                input logic [63:0] er, input logic [1:0] ee);
        vec_t v;
        v.is64 = is64; v.we = we; v.mode = mode; v.addr = addr; v.wdata = wdata;
        v.rdata = rdata; v.gnt_dly = gd; v.rv_dly = rd; v.early_rv = early;
        v.exp_mem = em; v.exp_maddr = ma; v.exp_strb = es; v.exp_wdata = ew;
        v.exp_rdata = er; v.exp_err = ee;
        return v;
    endfunction

    task automatic run_vec(input int idx, input vec_t v);
        exp_t e;
        bit   in_wait = 0;
        bit   seen_mem = 0;
        bit   done = 0;
        int   req_cnt = 0;
        int   wait_cnt = 0;
        string tag;
        tag = $sformatf("v%0d", idx);
        @(negedge clk);
        sel64 = v.is64; req_we = v.we; req_mode = v.mode; req_addr = v.addr;
        req_wdata = v.wdata; mem_rdata = v.rdata; mem_gnt = 0; mem_rvalid = 0;
        req_valid = 1;
        #1;
        check({tag, "_ready"}, o_ready, 1'b1);
        check({tag, "_stall_accept"}, o_stall, 1'b1);
        e.rdata = v.exp_rdata;
        e.err   = v.exp_err;
        if (!v.exp_mem)        e.lat = 1;
        else if (v.rv_dly < 0) e.lat = 2 + v.gnt_dly + 8;
        else                   e.lat = 3 + v.gnt_dly + v.rv_dly;
        exp_q.push_back(e);
        for (int cyc = 1; cyc <= 40 && !done; cyc++) begin
            @(negedge clk);
            if (o_rv) begin
                e = exp_q.pop_front();
                check({tag, "_latency"}, 64'(cyc), 64'(e.lat));
                check({tag, "_rdata"}, o_rdata, e.rdata);
                check({tag, "_err"}, o_err, e.err);
                check({tag, "_stall_rsp"}, o_stall, 1'b0);
                req_valid = 0; mem_gnt = 0; mem_rvalid = 0;
                done = 1;
            end else begin
                check({tag, "_stall"}, o_stall, 1'b1);
                if (in_wait) begin
                    mem_gnt    = 0;
                    mem_rvalid = (v.rv_dly >= 0) && (wait_cnt == v.rv_dly);
                    wait_cnt++;
                end else if (o_mreq) begin
                    if (!seen_mem) begin
                        seen_mem = 1;
                        check({tag, "_maddr"}, o_maddr, v.exp_maddr);
                        check({tag, "_mwe"}, o_mwe, v.we);
                        if (v.we) begin
                            check({tag, "_wstrb"}, o_strb, v.exp_strb);
                            check({tag, "_wdata"}, o_mwdata, v.exp_wdata);
                        end
                    end
                    if (req_cnt == v.gnt_dly) begin
                        mem_gnt    = 1;
                        mem_rvalid = v.early_rv;
                        in_wait    = 1;
                    end else begin
                        mem_gnt = 0;
                    end
                    req_cnt++;
                end
            end
        end
        check({tag, "_mem_access"}, seen_mem, v.exp_mem);
        if (!done) begin
            failures++;
            $display("FAIL %s_no_response: got none expected rsp_valid within 40 cycles", tag);
            void'(exp_q.pop_front());
            req_valid = 0; mem_gnt = 0; mem_rvalid = 0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 0; sel64 = 0; req_valid = 0; req_we = 0; req_mode = 0; req_addr = 0;
        req_wdata = 0; mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;

        //        64 we mode    addr      wdata                  rdata                  gd rd er em maddr     strb   exp_wdata              exp_rdata              err
        vecs.push_back(mk(0, 0, 3'b010, 32'h104, 64'h0,                 64'hDEADBEEF,          0, 0, 0, 1, 32'h104, 8'h00, 64'h0,                 64'hDEADBEEF,          2'b00));
        vecs.push_back(mk(0, 0, 3'b000, 32'h103, 64'h0,                 64'h80FF0000,          0, 0, 0, 1, 32'h100, 8'h00, 64'h0,                 64'hFFFFFF80,          2'b00));
        vecs.push_back(mk(0, 0, 3'b100, 32'h103, 64'h0,                 64'h80FF0000,          0, 0, 0, 1, 32'h100, 8'h00, 64'h0,                 64'h00000080,          2'b00));
        vecs.push_back(mk(0, 1, 3'b001, 32'h022, 64'h0000ABCD,          64'h0,                 2, 1, 0, 1, 32'h020, 8'h0C, 64'hABCD0000,          64'h0,                 2'b00));
        vecs.push_back(mk(0, 0, 3'b010, 32'h101, 64'h0,                 64'h0,                 0, 0, 0, 0, 32'h0,   8'h00, 64'h0,                 64'h0,                 2'b01));
        vecs.push_back(mk(0, 0, 3'b111, 32'h100, 64'h0,                 64'h0,                 0, 0, 0, 0, 32'h0,   8'h00, 64'h0,                 64'h0,                 2'b11));
        vecs.push_back(mk(0, 0, 3'b111, 32'h101, 64'h0,                 64'h0,                 0, 0, 0, 0, 32'h0,   8'h00, 64'h0,                 64'h0,                 2'b11));
        vecs.push_back(mk(0, 0, 3'b011, 32'h100, 64'h0,                 64'h0,                 0, 0, 0, 0, 32'h0,   8'h00, 64'h0,                 64'h0,                 2'b11));
        vecs.push_back(mk(0, 0, 3'b110, 32'h104, 64'h0,                 64'h0,                 0, 0, 0, 0, 32'h0,   8'h00, 64'h0,                 64'h0,                 2'b11));
        vecs.push_back(mk(0, 0, 3'b001, 32'h102, 64'h0,                 64'h80011234,          1, 0, 0, 1, 32'h100, 8'h00, 64'h0,                 64'hFFFF8001,          2'b00));
        vecs.push_back(mk(0, 0, 3'b101, 32'h102, 64'h0,                 64'h80011234,          0, 2, 0, 1, 32'h100, 8'h00, 64'h0,                 64'h00008001,          2'b00));
        vecs.push_back(mk(0, 0, 3'b001, 32'h101, 64'h0,                 64'h0,                 0, 0, 0, 0, 32'h0,   8'h00, 64'h0,                 64'h0,                 2'b01));
        vecs.push_back(mk(0, 1, 3'b000, 32'h013, 64'h123456A5,          64'h0,                 0, 0, 0, 1, 32'h010, 8'h08, 64'hA5000000,          64'h0,                 2'b00));
        vecs.push_back(mk(0, 1, 3'b010, 32'h040, 64'hCAFEF00D,          64'h0,                 0, 3, 0, 1, 32'h040, 8'h0F, 64'hCAFEF00D,          64'h0,                 2'b00));
        vecs.push_back(mk(0, 0, 3'b010, 32'h200, 64'h0,                 64'h11223344,          0, 2, 1, 1, 32'h200, 8'h00, 64'h0,                 64'h11223344,          2'b00));
        vecs.push_back(mk(0, 0, 3'b010, 32'h300, 64'h0,                 64'h55555555,          1, -1, 0, 1, 32'h300, 8'h00, 64'h0,                64'h0,                 2'b10));
        vecs.push_back(mk(0, 1, 3'b010, 32'h042, 64'h12345678,          64'h0,                 0, 0, 0, 0, 32'h0,   8'h00, 64'h0,                 64'h0,                 2'b01));
        vecs.push_back(mk(0, 0, 3'b000, 32'h100, 64'h0,                 64'h0000007F,          0, 0, 0, 1, 32'h100, 8'h00, 64'h0,                 64'h0000007F,          2'b00));
        vecs.push_back(mk(1, 0, 3'b011, 32'h008, 64'h0,                 64'hFFFFFFFF12345678,  0, 0, 0, 1, 32'h008, 8'h00, 64'h0,                 64'hFFFFFFFF12345678,  2'b00));
        vecs.push_back(mk(1, 0, 3'b110, 32'h00C, 64'h0,                 64'hFFFFFFFF12345678,  0, 0, 0, 1, 32'h008, 8'h00, 64'h0,                 64'h00000000FFFFFFFF,  2'b00));
        vecs.push_back(mk(1, 0, 3'b010, 32'h00C, 64'h0,                 64'hFFFFFFFF12345678,  0, 1, 0, 1, 32'h008, 8'h00, 64'h0,                 64'hFFFFFFFFFFFFFFFF,  2'b00));
        vecs.push_back(mk(1, 1, 3'b011, 32'h010, 64'h0123456789ABCDEF,  64'h0,                 1, 0, 0, 1, 32'h010, 8'hFF, 64'h0123456789ABCDEF,  64'h0,                 2'b00));
        vecs.push_back(mk(1, 1, 3'b010, 32'h014, 64'h00000000DEADBEEF,  64'h0,                 0, 0, 0, 1, 32'h010, 8'hF0, 64'hDEADBEEF00000000,  64'h0,                 2'b00));
        vecs.push_back(mk(1, 0, 3'b011, 32'h00C, 64'h0,                 64'h0,                 0, 0, 0, 0, 32'h0,   8'h00, 64'h0,                 64'h0,                 2'b01));
        vecs.push_back(mk(1, 0, 3'b111, 32'h008, 64'h0,                 64'h0,                 0, 0, 0, 0, 32'h0,   8'h00, 64'h0,                 64'h0,                 2'b11));
        vecs.push_back(mk(1, 0, 3'b001, 32'h00E, 64'h0,                 64'h7FFF000000000000,  0, 0, 0, 1, 32'h008, 8'h00, 64'h0,                 64'h0000000000007FFF,  2'b00));
        vecs.push_back(mk(1, 0, 3'b011, 32'h018, 64'h0,                 64'h0,                 0, -1, 0, 1, 32'h018, 8'h00, 64'h0,                64'h0,                 2'b10));
        vecs.push_back(mk(1, 0, 3'b010, 32'h000, 64'h0,                 64'hAAAAAAAA87654321,  0, 0, 0, 1, 32'h000, 8'h00, 64'h0,                 64'hFFFFFFFF87654321,  2'b00));

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1;
        #1;
        check("rst_ready32", ready32, 1'b1);
        check("rst_ready64", ready64, 1'b1);
        check("rst_stall", stall32, 1'b0);
        check("rst_rsp_valid", rv32, 1'b0);
        check("rst_mem_req", mreq32, 1'b0);
        check("rst_rsp_err", err32, 2'b00);
        check("rst_rsp_rdata", rdata64, 64'h0);
        check("rst_mem_wstrb", strb64, 8'h00);

        foreach (vecs[i]) run_vec(i, vecs[i]);

        // Response data holds after the last load, a late rvalid in IDLE is ignored
        @(negedge clk);
        mem_rvalid = 1;
        @(negedge clk);
        check("hold_rdata", o_rdata, vecs[vecs.size()-1].exp_rdata);
        check("late_rvalid_ignored64", rv64, 1'b0);
        check("late_rvalid_ignored32", rv32, 1'b0);
        mem_rvalid = 0;
        @(negedge clk);
        check("hold_rdata_2", o_rdata, vecs[vecs.size()-1].exp_rdata);
        check("idle_no_mem_req", mreq64, 1'b0);

        // Asynchronous reset while the 64-bit unit waits in WAIT
        @(negedge clk);
        sel64 = 1; req_we = 0; req_mode = 3'b011; req_addr = 32'h8;
        mem_rdata = 64'h0123456789ABCDEF; req_valid = 1;
        @(negedge clk);
        check("rst_seq_mem_req", mreq64, 1'b1);
        check("rst_seq_mem_addr", maddr64, 32'h8);
        mem_gnt = 1;
        @(negedge clk);
        mem_gnt = 0;
        check("rst_seq_in_wait", mreq64, 1'b0);
        check("rst_seq_stall", stall64, 1'b1);
        #2 reset = 0;
        #1;
        check("rst_async_mem_addr", maddr64, 32'h0);
        check("rst_async_rdata", rdata64, 64'h0);
        check("rst_async_ready", ready64, 1'b1);
        req_valid = 0;
        @(negedge clk);
        reset = 1;
        mem_rvalid = 1;
        @(negedge clk);
        mem_rvalid = 0;
        check("rst_late_rvalid", rv64, 1'b0);
        @(negedge clk);
        check("rst_late_rvalid_2", rv64, 1'b0);
        check("rst_final_ready", ready64, 1'b1);
        check("scoreboard_empty", 64'(exp_q.size()), 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
